// File: rtl/input_sel_pkg.sv
// Shared defaults and helpers for the input-source selector and its key debouncers.
package input_sel_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_SYNC  = 2;
  localparam int DEF_DB    = 1000;

  // Counter must hold values up to DB_CYCLES-1; sized from DB_CYCLES+1 to stay >= 1 bit.
  function automatic int db_cnt_width(input int db_cycles);
    return (db_cycles < 1) ? 1 : $clog2(db_cycles + 1);
  endfunction

endpackage

// File: rtl/key_debounce.sv
// One key channel: multi-flop synchroniser followed by a restart-on-bounce debounce counter.
module key_debounce
  import input_sel_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC,
  parameter int DB_CYCLES   = DEF_DB
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_key,
  output logic o_db,
  output logic o_idle
);

  localparam int              CW       = db_cnt_width(DB_CYCLES);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DB_CYCLES - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CW-1:0]          r_cnt;
  logic                   r_db;
  logic                   w_ks;

  assign w_ks = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_key};
    end
  end

  // Any return of ks to db drops the count, so only an unbroken run is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_db  <= 1'b0;
    end else if (w_ks == r_db) begin
      r_cnt <= '0;
    end else if (r_cnt == CNT_LAST) begin
      r_db  <= w_ks;
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_db   = r_db;
  assign o_idle = (r_cnt == '0);

endmodule

// File: rtl/input_source_mux.sv
// Per-channel key/logic source select with registered output and switch-qualified edge pulses.
module input_source_mux
  import input_sel_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int SYNC_STAGES = DEF_SYNC,
  parameter int DB_CYCLES   = DEF_DB
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_key,
  input  logic [WIDTH-1:0] key_mask,
  input  logic [WIDTH-1:0] key_in,
  input  logic [WIDTH-1:0] logic_in,
  output logic [WIDTH-1:0] rea_input,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             key_stable
);

  logic [WIDTH-1:0] w_db;
  logic [WIDTH-1:0] w_idle;
  logic [WIDTH-1:0] w_sel;
  logic [WIDTH-1:0] w_next;
  logic [WIDTH-1:0] w_chg;

  logic [WIDTH-1:0] r_sel_q;
  logic [WIDTH-1:0] r_rea;
  logic [WIDTH-1:0] r_rise;
  logic [WIDTH-1:0] r_fall;
  logic             r_key_stable;

  // Debouncers run regardless of select so a switch to key sees a settled value.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_key
      key_debounce #(
        .SYNC_STAGES (SYNC_STAGES),
        .DB_CYCLES   (DB_CYCLES)
      ) u_key_debounce (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_key  (key_in[gi]),
        .o_db   (w_db[gi]),
        .o_idle (w_idle[gi])
      );
    end
  endgenerate

  assign w_sel  = {WIDTH{en_key}} & key_mask;
  assign w_next = (w_sel & w_db) | (~w_sel & logic_in);
  assign w_chg  = w_sel ^ r_sel_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sel_q      <= '0;
      r_rea        <= '0;
      r_rise       <= '0;
      r_fall       <= '0;
      r_key_stable <= 1'b1;
    end else begin
      r_sel_q      <= w_sel;
      r_rea        <= w_next;
      r_rise       <= w_next & ~r_rea & ~w_chg;
      r_fall       <= ~w_next & r_rea & ~w_chg;
      r_key_stable <= &w_idle;
    end
  end

  assign rea_input  = r_rea;
  assign rise       = r_rise;
  assign fall       = r_fall;
  assign key_stable = r_key_stable;

endmodule

// File: tb/tb_input_source_mux.sv
// Directed bench: expected outputs queued per driven step, popped and checked after the edge.
module tb_input_source_mux;

  localparam int W = 16;

  typedef struct {
    string        tag;
    logic [W-1:0] rea;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         en_key;
  logic [W-1:0] key_mask;
  logic [W-1:0] key_in;
  logic [W-1:0] logic_in;
  logic [W-1:0] rea_input;
  logic [W-1:0] rise;
  logic [W-1:0] fall;
  logic         key_stable;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  input_source_mux #(
    .WIDTH       (W),
    .SYNC_STAGES (2),
    .DB_CYCLES   (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en_key     (en_key),
    .key_mask   (key_mask),
    .key_in     (key_in),
    .logic_in   (logic_in),
    .rea_input  (rea_input),
    .rise       (rise),
    .fall       (fall),
    .key_stable (key_stable)
  );

  always #5 clk = ~clk;

  task automatic push_exp(input string tag, input logic [W-1:0] er,
                          input logic [W-1:0] ers, input logic [W-1:0] efl);
    exp_t e;
    e.tag  = tag;
    e.rea  = er;
    e.rise = ers;
    e.fall = efl;
    sb_q.push_back(e);
  endtask

  task automatic check_front();
    exp_t e;
    n_tests++;
    assert (sb_q.size() > 0) else begin
      n_fail++;
      $error("FAIL scoreboard_empty: got 0 entries expected >=1");
    end
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      $display("[TB] %s rea=%h rise=%h fall=%h ks=%b", e.tag, rea_input, rise, fall, key_stable);
      n_tests++;
      assert (rea_input === e.rea) else begin
        n_fail++;
        $error("FAIL %s.rea: got %h expected %h", e.tag, rea_input, e.rea);
      end
      n_tests++;
      assert (rise === e.rise) else begin
        n_fail++;
        $error("FAIL %s.rise: got %h expected %h", e.tag, rise, e.rise);
      end
      n_tests++;
      assert (fall === e.fall) else begin
        n_fail++;
        $error("FAIL %s.fall: got %h expected %h", e.tag, fall, e.fall);
      end
      n_tests++;
      assert ((rise & fall) === '0) else begin
        n_fail++;
        $error("FAIL %s.excl: got %h expected %h", e.tag, rise & fall, 16'h0000);
      end
    end
  endtask

  task automatic step(input string tag, input logic [W-1:0] er,
                      input logic [W-1:0] ers, input logic [W-1:0] efl);
    push_exp(tag, er, ers, efl);
    @(posedge clk);
    #1;
    check_front();
  endtask

  task automatic chk_ks(input string tag, input logic exp_ks);
    n_tests++;
    assert (key_stable === exp_ks) else begin
      n_fail++;
      $error("FAIL %s: got %b expected %b", tag, key_stable, exp_ks);
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    en_key   = 1'b0;
    key_mask = '0;
    key_in   = 16'hFFFF;
    logic_in = 16'hFFFF;
    repeat (3) @(posedge clk);
    #1;
    push_exp("reset", 16'h0000, 16'h0000, 16'h0000);
    check_front();
    chk_ks("reset_ks", 1'b1);

    // Release: logic path loads FFFF on the first edge with a full rise.
    rst_n  = 1'b1;
    key_in = 16'h0000;
    step("release", 16'hFFFF, 16'hFFFF, 16'h0000);
    step("release_hold", 16'hFFFF, 16'h0000, 16'h0000);

    logic_in = 16'h0000; step("logic_clr", 16'h0000, 16'h0000, 16'hFFFF);
    logic_in = 16'h00A5; step("logic_a5", 16'h00A5, 16'h00A5, 16'h0000);
    step("logic_a5_hold", 16'h00A5, 16'h0000, 16'h0000);
    logic_in = 16'h0005; step("logic_05", 16'h0005, 16'h0000, 16'h00A0);
    logic_in = 16'h0004; step("toggle1", 16'h0004, 16'h0000, 16'h0001);
    logic_in = 16'h0005; step("toggle2", 16'h0005, 16'h0001, 16'h0000);
    logic_in = 16'h0004; step("toggle3", 16'h0004, 16'h0000, 16'h0001);
    logic_in = 16'h0000; step("logic_zero", 16'h0000, 16'h0000, 16'h0004);

    // Debounce accept: 7-edge latency for a clean step.
    en_key = 1'b1; key_mask = 16'h0001;
    step("sel_key0", 16'h0000, 16'h0000, 16'h0000);
    key_in = 16'h0001;
    for (int k = 0; k < 6; k++) step("db_wait", 16'h0000, 16'h0000, 16'h0000);
    chk_ks("db_busy_ks", 1'b0);
    step("db_accept", 16'h0001, 16'h0001, 16'h0000);
    chk_ks("db_idle_ks", 1'b1);
    step("db_hold", 16'h0001, 16'h0000, 16'h0000);

    key_in = 16'h0000;
    for (int k = 0; k < 6; k++) step("db_rel_wait", 16'h0001, 16'h0000, 16'h0000);
    step("db_release", 16'h0000, 16'h0000, 16'h0001);

    // Bounce: 1,0 for two cycles each, then hold 1.
    key_in = 16'h0001;
    step("bounce_a", 16'h0000, 16'h0000, 16'h0000);
    step("bounce_a", 16'h0000, 16'h0000, 16'h0000);
    key_in = 16'h0000;
    step("bounce_b", 16'h0000, 16'h0000, 16'h0000);
    step("bounce_b", 16'h0000, 16'h0000, 16'h0000);
    key_in = 16'h0001;
    for (int k = 0; k < 6; k++) step("bounce_wait", 16'h0000, 16'h0000, 16'h0000);
    step("bounce_accept", 16'h0001, 16'h0001, 16'h0000);
    step("bounce_hold1", 16'h0001, 16'h0000, 16'h0000);
    step("bounce_hold2", 16'h0001, 16'h0000, 16'h0000);

    // Source switch: channel 0 leaves key (1 -> 0) with no pulse.
    en_key = 1'b0; key_mask = 16'hFFFF; key_in = 16'h000F; logic_in = 16'hF000;
    step("sw_to_logic", 16'hF000, 16'hF000, 16'h0000);
    for (int k = 0; k < 8; k++) step("sw_settle", 16'hF000, 16'h0000, 16'h0000);
    en_key = 1'b1;
    step("sw_to_key", 16'h000F, 16'h0000, 16'h0000);
    step("sw_key_hold", 16'h000F, 16'h0000, 16'h0000);
    chk_ks("sw_ks", 1'b1);

    // Reset mid-count: pending change on bit 4 is discarded.
    key_in = 16'h001F;
    for (int k = 0; k < 4; k++) step("pre_rst", 16'h000F, 16'h0000, 16'h0000);
    rst_n = 1'b0;
    #1;
    push_exp("mid_reset", 16'h0000, 16'h0000, 16'h0000);
    check_front();
    chk_ks("mid_reset_ks", 1'b1);
    step("mid_reset_hold", 16'h0000, 16'h0000, 16'h0000);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step("post_rst_wait", 16'h0000, 16'h0000, 16'h0000);
      if (k == 4) chk_ks("post_rst_busy_ks", 1'b0);
    end
    step("post_rst_accept", 16'h001F, 16'h001F, 16'h0000);
    chk_ks("post_rst_idle_ks", 1'b1);
    step("post_rst_hold", 16'h001F, 16'h0000, 16'h0000);

    n_tests++;
    assert (sb_q.size() == 0) else begin
      n_fail++;
      $error("FAIL scoreboard_left: got %0d entries expected 0", sb_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/input_source_mux.md
# input_source_mux

Parametrised input-source selector feeding the FPGA core's input bus. Each channel is driven either by a front-panel key or by the internal logic source. Key inputs are synchronised and debounced. The selected value is registered, and one-cycle rise/fall pulses are generated per channel, with spurious edges suppressed when a channel changes source.

## Interface
Parameters:
- WIDTH, 16: number of channels.
- SYNC_STAGES, 2: synchroniser flops on each key input; must be ≥2.
- DB_CYCLES, 1000: consecutive stable cycles needed to accept a key change; must be ≥1.

Ports:
- clk  in  1  single system clock; all logic runs on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- en_key  in  1  global key enable, synchronous to clk.
- key_mask  in  WIDTH  per-channel key permission, synchronous to clk.
- key_in  in  WIDTH  raw key inputs; asynchronous and bouncing.
- logic_in  in  WIDTH  internal logic source, synchronous to clk.
- rea_input  out  WIDTH  registered selected input.
- rise  out  WIDTH  one-cycle pulse on a qualified 0→1 transition of rea_input[i].
- fall  out  WIDTH  one-cycle pulse on a qualified 1→0 transition of rea_input[i].
- key_stable  out  1  high when no debouncer has a change pending.

## Operation
- **Channel select:** sel[i] = en_key & key_mask[i].
  - sel[i]=1: the channel takes its debounced key value.
  - sel[i]=0: the channel takes logic_in[i].
- **Synchroniser:** key_in[i] passes through SYNC_STAGES flops to give ks[i].
- **Debouncer (per channel):** state is db[i] plus a counter cnt[i] of width $clog2(DB_CYCLES+1).
  - ks[i]==db[i]: cnt ← 0.
  - ks[i]!=db[i] and cnt < DB_CYCLES-1: cnt ← cnt+1.
  - ks[i]!=db[i] and cnt == DB_CYCLES-1: db ← ks, cnt ← 0.
  - Any bounce (ks returning to db) before acceptance restarts the count from 0.
  - Debouncers run continuously regardless of sel, so a switch to key gives an already-settled value.
- **Output register:** rea_input ← sel ? db : logic_in, per bit.
- **Edge pulses:** computed against the previous rea_input, using next = sel ? db : logic_in.
  - rise[i] ← next[i] & ~rea_input[i] & ~chg[i].
  - fall[i] ← ~next[i] & rea_input[i] & ~chg[i].
  - chg[i] = sel[i] ^ sel_q[i], where sel_q is sel registered one cycle.
  - Effect: an output change caused by a source switch produces no pulse.
- **key_stable:** registered; equals the AND over all channels of (cnt[i]==0).
- **DB_CYCLES=1:** any sync change is accepted on the first differing cycle, so the block degenerates to sync plus a register.

## Timing
- **Reset values:** while rst_n=0, every flop is 0 (sync chain, db, cnt, sel_q, rea_input, rise, fall). key_stable resets to 1. Release is synchronous to clk; first update is on the first edge after release.
- **Reset mid-operation:** aborts any pending debounce count. There are no held pulses or partial state afterwards.
- **Logic path latency:** 1 cycle from logic_in to rea_input. rise/fall assert in the same cycle that rea_input shows the new value, for exactly one cycle.
- **Key path latency:** a key_in step that is stable from edge 0 appears on rea_input after SYNC_STAGES + DB_CYCLES + 1 edges. The pulse is aligned with that update.
- **Select path latency:** 1 cycle from en_key/key_mask to rea_input. Pulses are blocked in the same cycle.
- **Simultaneous events:**
  - Select change together with a source value change: no pulse.
  - Back-to-back logic_in toggles: a pulse in every cycle, alternating rise and fall.
  - rise[i] and fall[i] are never high together.
- **Counter:** saturates by construction (reset at DB_CYCLES-1), so it never wraps.

## Structure
- **Package input_sel_pkg:** default parameter constants (DEF_WIDTH=16, DEF_SYNC=2, DEF_DB=1000) and a debounce-counter width function.
- **Sub-module key_debounce:** one channel, containing the synchroniser, counter and db. It exposes db and an idle flag, and is instantiated WIDTH times with generate.
- **Top level:** holds select, output register, edge logic and key_stable.

## Test plan
Simulation parameters: WIDTH=16, SYNC_STAGES=2, DB_CYCLES=4.
1. **Reset:** assert rst_n=0 with key_in=16'hFFFF and logic_in=16'hFFFF → rea_input=0, rise=fall=0, key_stable=1. First edge after release with en_key=0 → rea_input=16'hFFFF, rise=16'hFFFF for 1 cycle.
2. **Logic path:** en_key=0, logic_in 16'h0000→16'h00A5 → next cycle rea_input=16'h00A5, rise=16'h00A5 for 1 cycle. Then 16'h00A5→16'h0005 → fall=16'h00A0.
3. **Debounce accept:** en_key=1, key_mask=16'h0001, clean key_in[0] step 0→1 → rea_input[0]=1 exactly 7 edges later, rise[0] pulses once, key_stable low during the count.
4. **Bounce filter:** key_in[0] toggles 1,0,1 at 2-cycle intervals, then holds 1 → no update until 4 consecutive stable synchronised cycles. Exactly one rise[0].
5. **Source switch:** key db=16'h000F, logic_in=16'hF000, en_key 0→1 with key_mask=16'hFFFF → rea_input=16'h000F next cycle, rise=fall=0.
6. **Reset mid-count:** pulse rst_n low at count 2 of a pending key change → cnt and db cleared. After release, the full 7-edge latency applies again.
